// File: rtl/lcd_cmd_scheduler.sv
// Two-requester command scheduler for an HD44780-style character LCD.
// Replays a fixed power-on sequence, then arbitrates round-robin and times each panel write.
module lcd_cmd_scheduler #(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_CYC       = 12,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned WAIT_CYC     = 50,
  parameter int unsigned CLR_WAIT_CYC = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [9:0] code0,
  input  logic       req1,
  input  logic [9:0] code1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [9:0] lcd_code,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned Max01  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned Max23  = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int unsigned Max03  = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned MaxCyc = (Max03 > CLR_WAIT_CYC) ? Max03 : CLR_WAIT_CYC;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef enum logic [2:0] {
    StInitLoad,
    StSetup,
    StPulse,
    StHold,
    StWait,
    StIdle
  } state_e;

  // Timer holds remaining cycles minus one; a state exits when it reads zero.
  function automatic logic [TimerW-1:0] ld(input int unsigned n);
    return (n == 0) ? '0 : TimerW'(n - 1);
  endfunction

  function automatic logic [9:0] init_code(input logic [1:0] idx);
    logic [9:0] c;
    unique case (idx)
      2'd0:    c = 10'h001;
      2'd1:    c = 10'h030;
      2'd2:    c = 10'h00E;
      default: c = 10'h006;
    endcase
    return c;
  endfunction

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [9:0]          code_q, code_d;
  logic                en_q, en_d;
  logic [1:0]          idx_q, idx_d;
  logic                done_q, done_d;
  logic                last_q, last_d;
  logic                gnt0_c, gnt1_c;
  logic                timer_zero;
  logic                win0, win1;
  logic                slow_cmd;

  assign timer_zero = (timer_q == '0);
  assign slow_cmd   = (code_q == 10'h001) || (code_q == 10'h002);
  // Requester 0 wins a tie only when requester 1 was granted last.
  assign win0       = req0 && (!req1 || last_q);
  assign win1       = req1 && !win0;

  always_comb begin
    state_d = state_q;
    timer_d = timer_zero ? '0 : timer_q - TimerW'(1);
    code_d  = code_q;
    idx_d   = idx_q;
    done_d  = done_q;
    last_d  = last_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    unique case (state_q)
      StInitLoad: begin
        code_d  = init_code(idx_q);
        state_d = StSetup;
        timer_d = ld(SETUP_CYC);
      end
      StSetup: begin
        if (timer_zero) begin
          state_d = StPulse;
          timer_d = ld(EN_CYC);
        end
      end
      StPulse: begin
        if (timer_zero) begin
          state_d = StHold;
          timer_d = ld(HOLD_CYC);
        end
      end
      StHold: begin
        if (timer_zero) begin
          state_d = StWait;
          timer_d = slow_cmd ? ld(CLR_WAIT_CYC) : ld(WAIT_CYC);
        end
      end
      StWait: begin
        if (timer_zero) begin
          timer_d = '0;
          if (!done_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            state_d = StInitLoad;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StIdle: begin
        timer_d = '0;
        if (done_q && win0) begin
          gnt0_c  = 1'b1;
          code_d  = code0;
          last_d  = 1'b0;
          state_d = StSetup;
          timer_d = ld(SETUP_CYC);
        end else if (done_q && win1) begin
          gnt1_c  = 1'b1;
          code_d  = code1;
          last_d  = 1'b1;
          state_d = StSetup;
          timer_d = ld(SETUP_CYC);
        end
      end
      default: begin
        state_d = StInitLoad;
        timer_d = '0;
      end
    endcase
    en_d = (state_d == StPulse);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StInitLoad;
      timer_q <= '0;
      code_q  <= '0;
      en_q    <= 1'b0;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign gnt0      = rst && gnt0_c;
  assign gnt1      = rst && gnt1_c;
  assign busy      = rst && (state_q != StIdle);
  assign lcd_on    = rst;
  assign lcd_code  = code_q;
  assign lcd_en    = en_q;
  assign init_done = done_q;

endmodule
